demux_n: RTL and testbench

Parametrised 1-to-N demultiplexer for the PHY receive path, generalising the 2-lane demux to NUM_LANES lanes of DATA_W bits.
- A fast-clock word stream is distributed round-robin across lanes.
- Two modes:
  - direct: each word appears on its lane one cycle after it arrives.
  - aligned: a complete group of N words is presented on all lanes in the same cycle.
- Adds explicit lane resynchronisation and a group-complete strobe for downstream byte-striping logic.

---
 rtl/demux_n.sv | 100 ++++++++++
 tb/tb_demux_n.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_n.sv
// demux_n: 1-to-NUM_LANES receive-path demultiplexer.
// A stream of words arrives on the fast clock and is dealt round-robin
// across NUM_LANES lanes. There are two modes:
//   direct  - each word appears on its own lane one cycle after it arrives.
//   aligned - a complete group of NUM_LANES words is presented on all lanes
//             in the same cycle.
// sync_in, or any change of align_mode, restarts the lane rotation at lane 0
// and drops any partial aligned group.
module demux_n #(
    parameter int DATA_W    = 8,
    parameter int NUM_LANES = 2,
    parameter int PTR_W     = 1
) (
    input  logic                        clk_2f,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        valid_in,
    input  logic                        align_mode,
    input  logic                        sync_in,
    output logic [NUM_LANES*DATA_W-1:0] data_out,
    output logic [NUM_LANES-1:0]        valid_out,
    output logic [PTR_W-1:0]            lane_ptr,
    output logic                        group_done
);

    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);

    // Mode seen on the previous cycle. A difference from align_mode marks a
    // mode switch.
    logic              mode_q;
    // Aligned-mode holding area for lanes 0..NUM_LANES-2. The last lane is
    // taken straight from data_in when the group completes.
    logic [DATA_W-1:0] staging [NUM_LANES-1];

    logic              resync;     // restart the rotation at lane 0 this cycle
    logic [PTR_W-1:0]  eff_ptr;    // lane the current word is handled as
    logic              last_word;  // current valid word completes a group
    logic [PTR_W-1:0]  next_ptr;

    // Work out which lane the current word targets and where the pointer goes next.
    // NOTE: every signal gets a value on every path through this block, so
    // no latch can be inferred.
    always_comb begin
        resync    = sync_in | (align_mode != mode_q);
        eff_ptr   = resync ? '0 : lane_ptr;
        last_word = valid_in & (eff_ptr == LAST_LANE);
        next_ptr  = eff_ptr;
        if (valid_in) begin
            next_ptr = last_word ? '0 : eff_ptr + PTR_W'(1);
        end
    end

    // Registered lane outputs, staging area, pointer and stored mode.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            mode_q     <= 1'b0;
            lane_ptr   <= '0;
            data_out   <= '0;
            valid_out  <= '0;
            group_done <= 1'b0;
            // NOTE: staging is built from flops, not RAM, so it can be reset
            // here. Resetting it keeps every lane value deterministic.
            for (int k = 0; k < NUM_LANES - 1; k++) begin
                staging[k] <= '0;
            end
        end else begin
            mode_q     <= align_mode;
            lane_ptr   <= next_ptr;
            valid_out  <= '0;
            group_done <= 1'b0;
            if (valid_in) begin
                if (!align_mode) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (eff_ptr == PTR_W'(k)) begin
                            data_out[k*DATA_W +: DATA_W] <= data_in;
                        end
                    end
                    valid_out  <= NUM_LANES'(1) << eff_ptr;
                    group_done <= last_word;
                end else if (last_word) begin
                    for (int k = 0; k < NUM_LANES - 1; k++) begin
                        data_out[k*DATA_W +: DATA_W] <= staging[k];
                    end
                    data_out[(NUM_LANES-1)*DATA_W +: DATA_W] <= data_in;
                    valid_out  <= '1;
                    group_done <= 1'b1;
                end else begin
                    for (int k = 0; k < NUM_LANES - 1; k++) begin
                        if (eff_ptr == PTR_W'(k)) begin
                            staging[k] <= data_in;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_n.sv
// tb_demux_n: table-driven check of demux_n using three instances
// (2, 4 and 3 lanes). Each instance shares the clock and reset.
module tb_demux_n;

    logic clk_2f = 1'b0;
    logic reset  = 1'b0;

    always #5 clk_2f = ~clk_2f;

    // Instance 0: NUM_LANES=2
    logic [7:0]  d0_in;
    logic        v0_in, m0_in, s0_in;
    logic [15:0] d0_out;
    logic [1:0]  v0_out;
    logic [0:0]  p0_out;
    logic        g0_out;
    // Instance 1: NUM_LANES=4
    logic [7:0]  d1_in;
    logic        v1_in, m1_in, s1_in;
    logic [31:0] d1_out;
    logic [3:0]  v1_out;
    logic [1:0]  p1_out;
    logic        g1_out;
    // Instance 2: NUM_LANES=3
    logic [7:0]  d2_in;
    logic        v2_in, m2_in, s2_in;
    logic [23:0] d2_out;
    logic [2:0]  v2_out;
    logic [1:0]  p2_out;
    logic        g2_out;

    demux_n #(.DATA_W(8), .NUM_LANES(2), .PTR_W(1)) dut0 (
        .clk_2f(clk_2f), .reset(reset), .data_in(d0_in), .valid_in(v0_in),
        .align_mode(m0_in), .sync_in(s0_in), .data_out(d0_out),
        .valid_out(v0_out), .lane_ptr(p0_out), .group_done(g0_out)
    );
    demux_n #(.DATA_W(8), .NUM_LANES(4), .PTR_W(2)) dut1 (
        .clk_2f(clk_2f), .reset(reset), .data_in(d1_in), .valid_in(v1_in),
        .align_mode(m1_in), .sync_in(s1_in), .data_out(d1_out),
        .valid_out(v1_out), .lane_ptr(p1_out), .group_done(g1_out)
    );
    demux_n #(.DATA_W(8), .NUM_LANES(3), .PTR_W(2)) dut2 (
        .clk_2f(clk_2f), .reset(reset), .data_in(d2_in), .valid_in(v2_in),
        .align_mode(m2_in), .sync_in(s2_in), .data_out(d2_out),
        .valid_out(v2_out), .lane_ptr(p2_out), .group_done(g2_out)
    );

    typedef struct {
        int         dut;
        logic       vld;
        logic [7:0] din;
        logic       mode;
        logic       sync;
        logic [31:0] exp_data;
        logic [3:0]  exp_valid;
        logic [2:0]  exp_ptr;
        logic        exp_gd;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int dut, input logic vld, input logic [7:0] din,
                       input logic mode, input logic sync, input logic [31:0] ed,
                       input logic [3:0] ev, input logic [2:0] ep, input logic eg);
        vec_t v;
        v.dut = dut; v.vld = vld; v.din = din; v.mode = mode; v.sync = sync;
        v.exp_data = ed; v.exp_valid = ev; v.exp_ptr = ep; v.exp_gd = eg;
        vecs.push_back(v);
    endtask

    // Unselected instances see no valid word and no sync; their mode holds.
    task automatic drive(input int dut, input logic vld, input logic [7:0] din,
                         input logic mode, input logic sync);
        v0_in = 1'b0; s0_in = 1'b0;
        v1_in = 1'b0; s1_in = 1'b0;
        v2_in = 1'b0; s2_in = 1'b0;
        case (dut)
            0: begin v0_in = vld; d0_in = din; m0_in = mode; s0_in = sync; end
            1: begin v1_in = vld; d1_in = din; m1_in = mode; s1_in = sync; end
            default: begin v2_in = vld; d2_in = din; m2_in = mode; s2_in = sync; end
        endcase
    endtask

    task automatic get(input int dut, output logic [31:0] d, output logic [3:0] v,
                       output logic [2:0] p, output logic g);
        case (dut)
            0: begin d = {16'h0, d0_out}; v = {2'b0, v0_out}; p = {2'b0, p0_out}; g = g0_out; end
            1: begin d = d1_out; v = v1_out; p = {1'b0, p1_out}; g = g1_out; end
            default: begin d = {8'h0, d2_out}; v = {1'b0, v2_out}; p = {1'b0, p2_out}; g = g2_out; end
        endcase
    endtask

    task automatic check_dut(input string tag, input int dut, input logic [31:0] ed,
                             input logic [3:0] ev, input logic [2:0] ep, input logic eg);
        logic [31:0] d;
        logic [3:0]  v;
        logic [2:0]  p;
        logic        g;
        get(dut, d, v, p, g);
        check({tag, "_data"},  d, ed);
        check({tag, "_valid"}, {28'h0, v}, {28'h0, ev});
        check({tag, "_ptr"},   {29'h0, p}, {29'h0, ep});
        check({tag, "_gd"},    {31'h0, g}, {31'h0, eg});
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input int dut, input logic vld, input logic [7:0] din,
                        input logic mode, input logic sync);
        @(negedge clk_2f);
        drive(dut, vld, din, mode, sync);
        @(posedge clk_2f);
        #1;
    endtask

    initial begin
        d0_in = '0; v0_in = 0; m0_in = 0; s0_in = 0;
        d1_in = '0; v1_in = 0; m1_in = 0; s1_in = 0;
        d2_in = '0; v2_in = 0; m2_in = 0; s2_in = 0;

        // 2 lanes, direct mode
        add(0, 1, 8'hA1, 0, 0, 32'h0000_00A1, 4'b0001, 3'd1, 0);
        add(0, 1, 8'hB2, 0, 0, 32'h0000_B2A1, 4'b0010, 3'd0, 1);
        add(0, 1, 8'hC3, 0, 0, 32'h0000_B2C3, 4'b0001, 3'd1, 0);
        add(0, 1, 8'hD4, 0, 0, 32'h0000_D4C3, 4'b0010, 3'd0, 1);
        add(0, 0, 8'h00, 0, 0, 32'h0000_D4C3, 4'b0000, 3'd0, 0);
        // 3 lanes, direct mode, pointer wraps from 2 to 0
        add(2, 1, 8'h00, 0, 0, 32'h0000_0000, 4'b0001, 3'd1, 0);
        add(2, 1, 8'h01, 0, 0, 32'h0000_0100, 4'b0010, 3'd2, 0);
        add(2, 1, 8'h02, 0, 0, 32'h0002_0100, 4'b0100, 3'd0, 1);
        add(2, 1, 8'h03, 0, 0, 32'h0002_0103, 4'b0001, 3'd1, 0);
        add(2, 1, 8'h04, 0, 0, 32'h0002_0403, 4'b0010, 3'd2, 0);
        add(2, 1, 8'h05, 0, 0, 32'h0005_0403, 4'b0100, 3'd0, 1);
        add(2, 1, 8'h06, 0, 0, 32'h0005_0406, 4'b0001, 3'd1, 0);
        add(2, 0, 8'h00, 0, 0, 32'h0005_0406, 4'b0000, 3'd1, 0);
        // 4 lanes, aligned mode with a gap after 0x11
        add(1, 1, 8'h10, 1, 0, 32'h0000_0000, 4'h0, 3'd1, 0);
        add(1, 1, 8'h11, 1, 0, 32'h0000_0000, 4'h0, 3'd2, 0);
        add(1, 0, 8'h00, 1, 0, 32'h0000_0000, 4'h0, 3'd2, 0);
        add(1, 1, 8'h12, 1, 0, 32'h0000_0000, 4'h0, 3'd3, 0);
        add(1, 1, 8'h13, 1, 0, 32'h1312_1110, 4'hF, 3'd0, 1);
        add(1, 0, 8'h00, 1, 0, 32'h1312_1110, 4'h0, 3'd0, 0);
        // sync discards the partial group 0x20/0x21
        add(1, 1, 8'h20, 1, 0, 32'h1312_1110, 4'h0, 3'd1, 0);
        add(1, 1, 8'h21, 1, 0, 32'h1312_1110, 4'h0, 3'd2, 0);
        add(1, 1, 8'h30, 1, 1, 32'h1312_1110, 4'h0, 3'd1, 0);
        add(1, 1, 8'h31, 1, 0, 32'h1312_1110, 4'h0, 3'd2, 0);
        add(1, 1, 8'h32, 1, 0, 32'h1312_1110, 4'h0, 3'd3, 0);
        add(1, 1, 8'h33, 1, 0, 32'h3332_3130, 4'hF, 3'd0, 1);
        add(1, 0, 8'h00, 1, 0, 32'h3332_3130, 4'h0, 3'd0, 0);
        // sync without a valid word returns the pointer to 0
        add(1, 1, 8'h60, 1, 0, 32'h3332_3130, 4'h0, 3'd1, 0);
        add(1, 0, 8'h00, 1, 1, 32'h3332_3130, 4'h0, 3'd0, 0);
        // sync coinciding with the last word of a group: no group is emitted
        add(1, 1, 8'h70, 1, 0, 32'h3332_3130, 4'h0, 3'd1, 0);
        add(1, 1, 8'h71, 1, 0, 32'h3332_3130, 4'h0, 3'd2, 0);
        add(1, 1, 8'h72, 1, 0, 32'h3332_3130, 4'h0, 3'd3, 0);
        add(1, 1, 8'h73, 1, 1, 32'h3332_3130, 4'h0, 3'd1, 0);
        add(1, 1, 8'h74, 1, 0, 32'h3332_3130, 4'h0, 3'd2, 0);
        add(1, 1, 8'h75, 1, 0, 32'h3332_3130, 4'h0, 3'd3, 0);
        add(1, 1, 8'h76, 1, 0, 32'h7675_7473, 4'hF, 3'd0, 1);
        // switch to direct, then flip to aligned while the pointer is at 2
        add(1, 0, 8'h00, 0, 0, 32'h7675_7473, 4'h0, 3'd0, 0);
        add(1, 1, 8'h41, 0, 0, 32'h7675_7441, 4'h1, 3'd1, 0);
        add(1, 1, 8'h42, 0, 0, 32'h7675_4241, 4'h2, 3'd2, 0);
        add(1, 1, 8'h40, 1, 0, 32'h7675_4241, 4'h0, 3'd1, 0);
        add(1, 1, 8'h43, 1, 0, 32'h7675_4241, 4'h0, 3'd2, 0);
        add(1, 1, 8'h44, 1, 0, 32'h7675_4241, 4'h0, 3'd3, 0);
        add(1, 1, 8'h45, 1, 0, 32'h4544_4340, 4'hF, 3'd0, 1);
        // mode change coinciding with the last word of a group
        add(1, 1, 8'h80, 1, 0, 32'h4544_4340, 4'h0, 3'd1, 0);
        add(1, 1, 8'h81, 1, 0, 32'h4544_4340, 4'h0, 3'd2, 0);
        add(1, 1, 8'h82, 1, 0, 32'h4544_4340, 4'h0, 3'd3, 0);
        add(1, 1, 8'h83, 0, 0, 32'h4544_4383, 4'h1, 3'd1, 0);

        // Reset state, checked while reset is still low across a clock edge.
        @(posedge clk_2f);
        #1;
        check_dut("rst0", 0, 32'h0, 4'h0, 3'd0, 1'b0);
        check_dut("rst1", 1, 32'h0, 4'h0, 3'd0, 1'b0);
        check_dut("rst2", 2, 32'h0, 4'h0, 3'd0, 1'b0);
        @(negedge clk_2f);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].dut, vecs[i].vld, vecs[i].din, vecs[i].mode, vecs[i].sync);
            check_dut($sformatf("vec%0d", i), vecs[i].dut, vecs[i].exp_data,
                      vecs[i].exp_valid, vecs[i].exp_ptr, vecs[i].exp_gd);
        end

        // Asynchronous reset in the middle of an aligned group
        step(1, 1, 8'h90, 1, 0);
        step(1, 1, 8'h91, 1, 0);
        step(1, 1, 8'h92, 1, 0);
        check_dut("pre_rst", 1, 32'h4544_4383, 4'h0, 3'd3, 1'b0);
        @(negedge clk_2f);
        drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_dut("async_rst1", 1, 32'h0, 4'h0, 3'd0, 1'b0);
        check("async_rst0_data", {16'h0, d0_out}, 32'h0);
        @(negedge clk_2f);
        reset = 1'b1;
        step(1, 1, 8'h50, 1, 0);
        check_dut("post_rst50", 1, 32'h0, 4'h0, 3'd1, 1'b0);
        step(1, 1, 8'h51, 1, 0);
        check_dut("post_rst51", 1, 32'h0, 4'h0, 3'd2, 1'b0);
        step(1, 1, 8'h52, 1, 0);
        check_dut("post_rst52", 1, 32'h0, 4'h0, 3'd3, 1'b0);
        step(1, 1, 8'h53, 1, 0);
        check_dut("post_rst53", 1, 32'h5352_5150, 4'hF, 3'd0, 1'b1);
        step(1, 0, 8'h00, 1, 0);
        check_dut("post_rst_idle", 1, 32'h5352_5150, 4'h0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
